// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline registers of the RV32 core.
// The state encoding doubles as the number of entries held.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FULL    = 2'd1,
        ST_SKIDDED = 2'd2
    } state_e;

    localparam int OCC_W = 2;

    localparam int IFID_CTRL_W  = 8;
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_CTRL_W  = 8;
    localparam int IDEX_DATA_W  = 112;
    localparam int EXMEM_CTRL_W = 8;
    localparam int EXMEM_DATA_W = 104;
    localparam int MEMWB_CTRL_W = 8;
    localparam int MEMWB_DATA_W = 72;

    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_BRANCH     = 3;
    localparam int CTRL_JUMP       = 4;
    localparam int CTRL_ALU_SRC    = 5;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_CSR        = 7;

    function automatic logic [OCC_W-1:0] state_occ(input state_e s);
        return OCC_W'(s);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload entry of a pipeline register: valid flag, control field and data field.
// Clearing empties the entry and zeroes control; the data field keeps its last value.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 112
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_clear) begin
            // NOTE: data is deliberately left alone on clear; only the valid bit and control are dropped.
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register between two core stages, with flush and an optional
// skid entry that lets in_ready come straight from a flop.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 112,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
);

    state_e            r_state;
    state_e            w_next_state;
    logic              r_in_ready;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_main_load;
    logic              w_main_clear;
    logic              w_main_from_skid;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              w_main_valid;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_comb begin
        w_next_state     = r_state;
        w_main_load      = 1'b0;
        w_main_clear     = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_next_state = ST_FULL;
                    w_main_load  = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_main_load = 1'b1;
                end else if (w_in_xfer) begin
                    w_next_state = ST_SKIDDED;
                    w_skid_load  = 1'b1;
                end else if (w_out_xfer) begin
                    w_next_state = ST_EMPTY;
                    w_main_clear = 1'b1;
                end
            end
            ST_SKIDDED: begin
                if (w_out_xfer) begin
                    w_next_state     = ST_FULL;
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_skid_clear     = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_EMPTY;
                w_main_clear = 1'b1;
                w_skid_clear = 1'b1;
            end
        endcase
        // A redirect empties the stage and drops whatever arrives in the same cycle.
        if (flush) begin
            w_next_state = ST_EMPTY;
            w_main_load  = 1'b0;
            w_skid_load  = 1'b0;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_SKIDDED);
        end
    end

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_ctrl  (w_main_from_skid ? w_skid_ctrl : in_ctrl),
        .i_data  (w_main_from_skid ? w_skid_data : in_data),
        .o_valid (w_main_valid),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clear),
                .i_ctrl  (in_ctrl),
                .i_data  (in_data),
                .o_valid (w_skid_valid),
                .o_ctrl  (w_skid_ctrl),
                .o_data  (w_skid_data)
            );
            // NOTE: in_ready comes from a flop so out_ready never reaches the upstream stage combinationally.
            assign in_ready = r_in_ready;
        end else begin : g_no_skid
            assign w_skid_valid = 1'b0;
            assign w_skid_ctrl  = '0;
            assign w_skid_data  = '0;
            assign in_ready     = !w_main_valid || out_ready;
        end
    endgenerate

    assign out_valid = w_main_valid;
    assign out_ctrl  = w_main_valid ? w_main_ctrl : '0;
    assign out_data  = w_main_data;
    assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

    a_hold_stalled_input: assert property (@(posedge clk) disable iff (rst)
        (in_valid && !in_ready && !flush) |=> (in_valid && $stable(in_ctrl) && $stable(in_data)));
    a_occupancy_bound: assert property (@(posedge clk) disable iff (rst) occupancy != 2'd3);
    a_occupancy_state: assert property (@(posedge clk) disable iff (rst) occupancy == state_occ(r_state));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 instance under directed traffic and a SKID=0 instance
// under random traffic, both compared every cycle against a queue-based model.
module tb_pipe_stage_reg;

    localparam int CW = 8;
    localparam int DW = 112;

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b1;
    logic [CW-1:0] a_in_ctrl = '0;
    logic [DW-1:0] a_in_data = '0;
    logic          a_in_ready, a_out_valid;
    logic [CW-1:0] a_out_ctrl;
    logic [DW-1:0] a_out_data;
    logic [1:0]    a_occ;

    logic          b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [CW-1:0] b_in_ctrl = '0;
    logic [DW-1:0] b_in_data = '0;
    logic          b_in_ready, b_out_valid;
    logic [CW-1:0] b_out_ctrl;
    logic [DW-1:0] b_out_data;
    logic [1:0]    b_occ;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_dut_skid (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_dut_noskid (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: a FIFO of accepted entries (capacity 2 with skid, 1 without); the head is presented,
    // and out_data keeps showing the last head once the stage drains.
    entry_t        qa[$];
    entry_t        qb[$];
    logic [DW-1:0] a_last = '0;
    logic [DW-1:0] b_last = '0;
    logic [7:0]    a_log[$];

    always begin : model_a
        logic ev, er, ix, ox;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        @(negedge clk);
        #2;
        ev = (qa.size() != 0);
        ec = ev ? qa[0].ctrl : '0;
        ed = ev ? qa[0].data : a_last;
        er = (qa.size() < 2);
        check("a_out_valid", 128'(a_out_valid), 128'(ev));
        check("a_out_ctrl",  128'(a_out_ctrl),  128'(ec));
        check("a_out_data",  128'(a_out_data),  128'(ed));
        check("a_in_ready",  128'(a_in_ready),  128'(er));
        check("a_occupancy", 128'(a_occ),       128'(qa.size()));
        ix = a_in_valid && er;
        ox = ev && a_out_ready;
        if (rst) begin
            qa.delete();
            a_last = '0;
        end else begin
            if (ox) begin
                a_log.push_back(qa[0].data[7:0]);
                void'(qa.pop_front());
            end
            if (a_flush) qa.delete();
            else if (ix) qa.push_back('{a_in_ctrl, a_in_data});
            if (qa.size() != 0) a_last = qa[0].data;
        end
    end

    always begin : model_b
        logic ev, er, ix, ox;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        @(negedge clk);
        #2;
        ev = (qb.size() != 0);
        ec = ev ? qb[0].ctrl : '0;
        ed = ev ? qb[0].data : b_last;
        er = (qb.size() == 0) || b_out_ready;
        check("b_out_valid", 128'(b_out_valid), 128'(ev));
        check("b_out_ctrl",  128'(b_out_ctrl),  128'(ec));
        check("b_out_data",  128'(b_out_data),  128'(ed));
        check("b_in_ready",  128'(b_in_ready),  128'(er));
        check("b_occupancy", 128'(b_occ),       128'(qb.size()));
        ix = b_in_valid && er;
        ox = ev && b_out_ready;
        if (rst) begin
            qb.delete();
            b_last = '0;
        end else begin
            if (ox) void'(qb.pop_front());
            if (b_flush) qb.delete();
            else if (ix) qb.push_back('{b_in_ctrl, b_in_data});
            if (qb.size() != 0) b_last = qb[0].data;
        end
    end

    // Bubbles (v=0) always carry in_ctrl=8'hFF so a leak into out_ctrl is visible.
    task automatic drive_a(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
        @(negedge clk);
        a_in_valid  = v;
        a_in_data   = DW'(d);
        a_in_ctrl   = ~d;
        a_out_ready = ordy;
        a_flush     = fl;
    endtask

    initial begin
        int   seq;
        logic b_pend;

        drive_a(0, 8'h00, 1, 0);
        drive_a(0, 8'h00, 1, 0);
        drive_a(0, 8'h00, 1, 0);
        rst = 1'b0;
        check("rst_out_valid", 128'(a_out_valid), 128'(0));
        check("rst_out_ctrl",  128'(a_out_ctrl),  128'(0));
        check("rst_out_data",  128'(a_out_data),  128'(0));
        check("rst_occ",       128'(a_occ),       128'(0));
        check("rst_in_ready",  128'(a_in_ready),  128'(1));

        for (int i = 1; i <= 16; i++) begin
            drive_a(1, 8'(i), 1, 0);
            if (i >= 2) begin
                check("stream_valid", 128'(a_out_valid), 128'(1));
                check("stream_data",  128'(a_out_data),  128'(i - 1));
            end
        end
        drive_a(0, 8'h00, 1, 0);
        check("stream_last_data", 128'(a_out_data), 128'(8'h10));
        check("stream_last_ctrl", 128'(a_out_ctrl), 128'(8'hEF));
        drive_a(0, 8'h00, 1, 0);
        check("bubble_valid", 128'(a_out_valid), 128'(0));
        check("bubble_ctrl",  128'(a_out_ctrl),  128'(0));
        check("bubble_data",  128'(a_out_data),  128'(8'h10));

        drive_a(1, 8'h11, 0, 0);
        drive_a(1, 8'h22, 0, 0);
        check("stall_occ1",     128'(a_occ),      128'(1));
        check("stall_ready1",   128'(a_in_ready), 128'(1));
        drive_a(0, 8'h00, 0, 0);
        check("stall_occ2",     128'(a_occ),      128'(2));
        check("stall_ready2",   128'(a_in_ready), 128'(0));
        check("stall_data",     128'(a_out_data), 128'(8'h11));
        check("stall_ctrl",     128'(a_out_ctrl), 128'(8'hEE));
        drive_a(0, 8'h00, 0, 0);
        check("stall_hold",     128'(a_out_data), 128'(8'h11));
        drive_a(0, 8'h00, 1, 0);
        check("release_ready0", 128'(a_in_ready), 128'(0));
        drive_a(0, 8'h00, 1, 0);
        check("release_data_b", 128'(a_out_data), 128'(8'h22));
        check("release_occ",    128'(a_occ),      128'(1));
        check("release_ready1", 128'(a_in_ready), 128'(1));
        drive_a(0, 8'h00, 1, 0);
        check("release_empty",  128'(a_out_valid), 128'(0));

        drive_a(1, 8'h44, 0, 0);
        drive_a(1, 8'h55, 0, 0);
        drive_a(1, 8'h33, 0, 1);
        check("flush_pre_occ",  128'(a_occ),       128'(2));
        drive_a(0, 8'h00, 1, 0);
        check("flush_occ",      128'(a_occ),       128'(0));
        check("flush_valid",    128'(a_out_valid), 128'(0));
        check("flush_ctrl",     128'(a_out_ctrl),  128'(0));
        check("flush_ready",    128'(a_in_ready),  128'(1));
        check("flush_data_old", 128'(a_out_data),  128'(8'h44));
        drive_a(0, 8'h00, 1, 0);
        drive_a(0, 8'h00, 1, 0);
        check("flush_no_c",     128'(a_out_valid), 128'(0));

        drive_a(1, 8'h66, 0, 0);
        drive_a(1, 8'h77, 0, 0);
        drive_a(0, 8'h00, 1, 0);
        rst = 1'b1;
        check("midrst_pre_occ", 128'(a_occ), 128'(2));
        drive_a(0, 8'h00, 1, 0);
        drive_a(0, 8'h00, 1, 0);
        rst = 1'b0;
        check("midrst_valid", 128'(a_out_valid), 128'(0));
        check("midrst_ctrl",  128'(a_out_ctrl),  128'(0));
        check("midrst_occ",   128'(a_occ),       128'(0));
        check("midrst_ready", 128'(a_in_ready),  128'(1));
        check("midrst_data",  128'(a_out_data),  128'(0));
        drive_a(1, 8'h99, 1, 0);
        drive_a(0, 8'h00, 1, 0);
        check("recover_data", 128'(a_out_data), 128'(8'h99));
        drive_a(0, 8'h00, 1, 0);

        check("log_size", 128'(a_log.size()), 128'(19));
        for (int i = 0; i < 16; i++)
            check("log_stream", 128'((i < a_log.size()) ? a_log[i] : 8'h00), 128'(i + 1));
        check("log_a", 128'((a_log.size() > 16) ? a_log[16] : 8'h00), 128'(8'h11));
        check("log_b", 128'((a_log.size() > 17) ? a_log[17] : 8'h00), 128'(8'h22));
        check("log_r", 128'((a_log.size() > 18) ? a_log[18] : 8'h00), 128'(8'h99));

        seq    = 0;
        b_pend = 1'b0;
        repeat (10000) begin
            @(negedge clk);
            if (!b_pend) begin
                b_in_valid = ($urandom_range(0, 1) == 1);
                if (b_in_valid) seq++;
                b_in_data = DW'(seq);
                b_in_ctrl = {seq[6:0], 1'b1};
            end
            b_out_ready = ($urandom_range(0, 3) != 0);
            b_flush     = ($urandom_range(0, 63) == 0);
            #4;
            b_pend = b_in_valid && !b_in_ready && !b_flush;
            check("b_occ_max", 128'(b_occ <= 2'd1), 128'(1));
        end
        @(negedge clk);
        b_in_valid  = 1'b0;
        b_flush     = 1'b0;
        b_out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
